// File: rtl/store_write_buffer_if.sv
// Cache-side and memory-side signal bundle for the posted store buffer.
// slave is the buffer's view; master is the cache/memory environment's view.
interface store_write_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cache_read_request;
    logic              cache_write_request;
    logic [ADDR_W-1:0] cache_addr;
    logic [DATA_W-1:0] cache_write_data;
    logic              cache_response;
    logic [DATA_W-1:0] cache_read_data;
    logic              memory_read_request;
    logic              memory_write_request;
    logic [ADDR_W-1:0] memory_addr;
    logic [DATA_W-1:0] memory_write_data;
    logic              memory_response;
    logic [DATA_W-1:0] memory_read_data;
    logic              buffer_empty;

    modport slave (
        input  cache_read_request, cache_write_request, cache_addr, cache_write_data,
        input  memory_response, memory_read_data,
        output cache_response, cache_read_data,
        output memory_read_request, memory_write_request, memory_addr, memory_write_data,
        output buffer_empty
    );

    modport master (
        output cache_read_request, cache_write_request, cache_addr, cache_write_data,
        output memory_response, memory_read_data,
        input  cache_response, cache_read_data,
        input  memory_read_request, memory_write_request, memory_addr, memory_write_data,
        input  buffer_empty
    );
endinterface

// File: rtl/store_write_buffer.sv
// Posted store buffer: stores are acked on enqueue and drained to memory in order;
// reads forward from the youngest buffered store or go to memory ahead of drains.
module store_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    store_write_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, DRAIN, READ, RESP} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              cache_resp_q, cache_resp_d;
    logic [DATA_W-1:0] cache_rdata_q, cache_rdata_d;
    logic              mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              empty_q, empty_d;

    logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
    logic [DATA_W-1:0] fifo_data_q [DEPTH];

    logic              push, pop, rd_req, hit;
    logic [DATA_W-1:0] hit_data;
    logic [PTR_W-1:0]  idx;

    // Scan oldest to youngest so the last match is the youngest store.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = head_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (fifo_addr_q[idx] == bus.cache_addr)) begin
                hit      = 1'b1;
                hit_data = fifo_data_q[idx];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        cache_resp_d  = 1'b0;
        cache_rdata_d = '0;
        mem_rd_d      = mem_rd_q;
        mem_wr_d      = mem_wr_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;

        pop    = (state_q == DRAIN) && bus.memory_response;
        push   = !cache_resp_q && bus.cache_write_request &&
                 ((count_q != CNT_W'(DEPTH)) || pop);
        rd_req = !cache_resp_q && bus.cache_read_request && !bus.cache_write_request &&
                 (state_q != READ) && (state_q != RESP);

        if (push) begin
            tail_d       = tail_q + PTR_W'(1);
            cache_resp_d = 1'b1;
        end
        if (pop) head_d = head_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);

        if (rd_req && hit) begin
            cache_resp_d  = 1'b1;
            cache_rdata_d = hit_data;
        end

        case (state_q)
            IDLE: begin
                if (rd_req && !hit) begin
                    state_d    = READ;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = bus.cache_addr;
                end else if (count_q != '0) begin
                    state_d     = DRAIN;
                    mem_wr_d    = 1'b1;
                    mem_addr_d  = fifo_addr_q[head_q];
                    mem_wdata_d = fifo_data_q[head_q];
                end
            end
            DRAIN: begin
                if (bus.memory_response) begin
                    state_d     = IDLE;
                    mem_wr_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                end
            end
            READ: begin
                if (bus.memory_response) begin
                    state_d       = RESP;
                    mem_rd_d      = 1'b0;
                    mem_addr_d    = '0;
                    cache_resp_d  = 1'b1;
                    cache_rdata_d = bus.memory_read_data;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        empty_d = (count_d == '0) && !mem_wr_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            cache_resp_q  <= 1'b0;
            cache_rdata_q <= '0;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            empty_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            cache_resp_q  <= cache_resp_d;
            cache_rdata_q <= cache_rdata_d;
            mem_rd_q      <= mem_rd_d;
            mem_wr_q      <= mem_wr_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            empty_q       <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[tail_q] <= bus.cache_addr;
            fifo_data_q[tail_q] <= bus.cache_write_data;
        end
    end

    assign bus.cache_response       = cache_resp_q;
    assign bus.cache_read_data      = cache_rdata_q;
    assign bus.memory_read_request  = mem_rd_q;
    assign bus.memory_write_request = mem_wr_q;
    assign bus.memory_addr          = mem_addr_q;
    assign bus.memory_write_data    = mem_wdata_q;
    assign bus.buffer_empty         = empty_q;
endmodule
